// File: rtl/bram2udp_pkg.sv
// ============================================================================
// Module      : bram2udp_pkg
// Description : Shared register map, AXI response codes and FSM encoding for
//               the bram2udp register/BRAM window initiator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bram2udp_pkg;

    localparam logic [15:0] REG_INT_ENABLE = 16'h0000;
    localparam logic [15:0] REG_INT_STATUS = 16'h0004;
    localparam logic [15:0] REG_SDLEN      = 16'h0008;
    localparam logic [15:0] REG_RDLEN      = 16'h000C;
    localparam logic [15:0] REG_STATUS     = 16'h0010;

    localparam logic [15:0] TX_BRAM_LO     = 16'h0800;
    localparam logic [15:0] TX_BRAM_HI     = 16'h0FFF;
    localparam logic [15:0] RX_BRAM_LO     = 16'h1000;
    localparam logic [15:0] RX_BRAM_HI     = 16'h17FF;

    typedef logic [1:0] axi_resp_t;
    localparam axi_resp_t RESP_OKAY    = 2'b00;
    localparam axi_resp_t RESP_SLVERR  = 2'b10;
    localparam axi_resp_t RESP_DECERR  = 2'b11;
    localparam axi_resp_t RESP_TIMEOUT = 2'b11;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_WR   = 3'd1;
    localparam state_t ST_WR_B = 3'd2;
    localparam state_t ST_RD_A = 3'd3;
    localparam state_t ST_RD_R = 3'd4;
    localparam state_t ST_RSP  = 3'd5;

    typedef struct packed {
        logic [31:0] rdata;
        axi_resp_t   resp;
        logic        tmo;
    } rsp_t;

    // Word-aligned bus address: the two byte-lane bits never reach the bus.
    function automatic logic [31:0] axil_addr(input logic [31:0] base, input logic [15:0] off);
        return base | {16'h0000, off & 16'hFFFC};
    endfunction

endpackage

`default_nettype wire

// File: rtl/axil_reg_master_if.sv
// ============================================================================
// Module      : axil_reg_master_if
// Description : AXI4-Lite channel bundle between the register initiator and
//               the bram2udp slave.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axil_reg_master_if;

    logic [31:0] axi_awaddr_o;
    logic        axi_awvalid_o;
    logic        axi_awready_i;
    logic [31:0] axi_wdata_o;
    logic [3:0]  axi_wstrb_o;
    logic        axi_wvalid_o;
    logic        axi_wready_i;
    logic [1:0]  axi_bresp_i;
    logic        axi_bvalid_i;
    logic        axi_bready_o;
    logic [31:0] axi_araddr_o;
    logic        axi_arvalid_o;
    logic        axi_arready_i;
    logic [31:0] axi_rdata_i;
    logic [1:0]  axi_rresp_i;
    logic        axi_rvalid_i;
    logic        axi_rready_o;

    modport master (
        output axi_awaddr_o, axi_awvalid_o, input axi_awready_i,
        output axi_wdata_o, axi_wstrb_o, axi_wvalid_o, input axi_wready_i,
        input  axi_bresp_i, axi_bvalid_i, output axi_bready_o,
        output axi_araddr_o, axi_arvalid_o, input axi_arready_i,
        input  axi_rdata_i, axi_rresp_i, axi_rvalid_i, output axi_rready_o
    );

    modport slave (
        input  axi_awaddr_o, axi_awvalid_o, output axi_awready_i,
        input  axi_wdata_o, axi_wstrb_o, axi_wvalid_o, output axi_wready_i,
        output axi_bresp_i, axi_bvalid_i, input axi_bready_o,
        input  axi_araddr_o, axi_arvalid_o, output axi_arready_i,
        output axi_rdata_i, axi_rresp_i, axi_rvalid_i, input axi_rready_o
    );

endinterface

`default_nettype wire

// File: rtl/axil_reg_master.sv
// ============================================================================
// Module      : axil_reg_master
// Description : Single-outstanding AXI4-Lite initiator turning register
//               commands into bus transactions, with timeout and error count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axil_reg_master
    import bram2udp_pkg::*;
#(
    parameter logic [31:0] BASEADDR       = 32'h4000_0000,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
    input  wire logic        sclk,
    input  wire logic        reset,
    input  wire logic        cmd_valid_i,
    output logic             cmd_ready_o,
    input  wire logic        cmd_write_i,
    input  wire logic [15:0] cmd_addr_i,
    input  wire logic [31:0] cmd_wdata_i,
    input  wire logic [3:0]  cmd_wstrb_i,
    output logic             rsp_valid_o,
    input  wire logic        rsp_ready_i,
    output logic [31:0]      rsp_rdata_o,
    output logic [1:0]       rsp_resp_o,
    output logic             rsp_timeout_o,
    output logic [15:0]      err_cnt_o,
    axil_reg_master_if.master axi
);

    state_t      state_q,   state_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q,  wvalid_d;
    logic        bready_q,  bready_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q,  rready_d;
    logic [31:0] addr_q,    addr_d;
    logic [31:0] wdata_q,   wdata_d;
    logic [3:0]  wstrb_q,   wstrb_d;
    logic [15:0] cnt_q,     cnt_d;
    logic        rsp_valid_q, rsp_valid_d;
    rsp_t        rsp_q,     rsp_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    logic [15:0] w_cnt_inc;
    logic        w_tmo;
    logic        w_aw_done;
    logic        w_w_done;
    logic        w_fin;
    logic        w_abort;
    rsp_t        w_fin_rsp;

    assign w_cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    assign w_tmo     = (TIMEOUT_CYCLES != 16'd0) && (w_cnt_inc >= TIMEOUT_CYCLES);
    assign w_aw_done = !awvalid_q || axi.axi_awready_i;
    assign w_w_done  = !wvalid_q  || axi.axi_wready_i;

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_d       = rsp_q;
        err_cnt_d   = err_cnt_q;
        w_fin       = 1'b0;
        w_abort     = 1'b0;
        w_fin_rsp   = '0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    cmd_ready_d = 1'b0;
                    cnt_d       = 16'd0;
                    addr_d      = axil_addr(BASEADDR, cmd_addr_i);
                    wdata_d     = cmd_wdata_i;
                    wstrb_d     = cmd_wstrb_i;
                    if (cmd_write_i) begin
                        state_d   = ST_WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = ST_RD_A;
                        arvalid_d = 1'b1;
                    end
                end
            end
            ST_WR: begin
                cnt_d     = w_cnt_inc;
                awvalid_d = awvalid_q && !axi.axi_awready_i;
                wvalid_d  = wvalid_q  && !axi.axi_wready_i;
                // Completing handshakes win over a coincident timeout.
                if (w_aw_done && w_w_done) begin
                    state_d  = ST_WR_B;
                    bready_d = 1'b1;
                end else if (w_tmo) begin
                    w_abort = 1'b1;
                end
            end
            ST_WR_B: begin
                cnt_d = w_cnt_inc;
                if (axi.axi_bvalid_i) begin
                    w_fin          = 1'b1;
                    w_fin_rsp.resp = axi.axi_bresp_i;
                end else if (w_tmo) begin
                    w_abort = 1'b1;
                end
            end
            ST_RD_A: begin
                cnt_d = w_cnt_inc;
                if (axi.axi_arready_i) begin
                    state_d   = ST_RD_R;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end else if (w_tmo) begin
                    w_abort = 1'b1;
                end
            end
            ST_RD_R: begin
                cnt_d = w_cnt_inc;
                if (axi.axi_rvalid_i) begin
                    w_fin           = 1'b1;
                    w_fin_rsp.rdata = axi.axi_rdata_i;
                    w_fin_rsp.resp  = axi.axi_rresp_i;
                end else if (w_tmo) begin
                    w_abort = 1'b1;
                end
            end
            ST_RSP: begin
                if (rsp_ready_i) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b1;
            end
        endcase

        if (w_abort) begin
            w_fin     = 1'b1;
            w_fin_rsp = '{rdata: 32'h0, resp: RESP_TIMEOUT, tmo: 1'b1};
        end

        // Every path into RSP releases the bus and accounts for errors here.
        if (w_fin) begin
            state_d     = ST_RSP;
            awvalid_d   = 1'b0;
            wvalid_d    = 1'b0;
            bready_d    = 1'b0;
            arvalid_d   = 1'b0;
            rready_d    = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_d       = w_fin_rsp;
            if ((w_fin_rsp.resp != RESP_OKAY) && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            wstrb_q     <= 4'h0;
            cnt_q       <= 16'd0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
            err_cnt_q   <= 16'd0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign cmd_ready_o       = cmd_ready_q;
    assign rsp_valid_o       = rsp_valid_q;
    assign rsp_rdata_o       = rsp_q.rdata;
    assign rsp_resp_o        = rsp_q.resp;
    assign rsp_timeout_o     = rsp_q.tmo;
    assign err_cnt_o         = err_cnt_q;
    assign axi.axi_awaddr_o  = addr_q;
    assign axi.axi_awvalid_o = awvalid_q;
    assign axi.axi_wdata_o   = wdata_q;
    assign axi.axi_wstrb_o   = wstrb_q;
    assign axi.axi_wvalid_o  = wvalid_q;
    assign axi.axi_bready_o  = bready_q;
    assign axi.axi_araddr_o  = addr_q;
    assign axi.axi_arvalid_o = arvalid_q;
    assign axi.axi_rready_o  = rready_q;

endmodule

`default_nettype wire

// File: tb/tb_axil_reg_master.sv
// ============================================================================
// Module      : tb_axil_reg_master
// Description : Vector table plus scoreboard bench for axil_reg_master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axil_reg_master;
    import bram2udp_pkg::*;

    localparam logic [15:0] TMO = 16'd8;

    logic        sclk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_write_i = 1'b0;
    logic [15:0] cmd_addr_i = '0;
    logic [31:0] cmd_wdata_i = '0;
    logic [3:0]  cmd_wstrb_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_rdata_o;
    logic [1:0]  rsp_resp_o;
    logic        rsp_timeout_o;
    logic [15:0] err_cnt_o;

    axil_reg_master_if axi();

    axil_reg_master #(.BASEADDR(32'h4000_0000), .TIMEOUT_CYCLES(TMO)) dut (
        .sclk(sclk), .reset(reset),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
        .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_wstrb_i(cmd_wstrb_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_resp_o(rsp_resp_o), .rsp_timeout_o(rsp_timeout_o), .err_cnt_o(err_cnt_o),
        .axi(axi)
    );

    always #5 sclk = ~sclk;

    typedef struct {
        logic wr; logic [15:0] addr; logic [31:0] wdata; logic [3:0] wstrb;
        int a_dly; int w_dly; int d_dly; logic [1:0] s_resp; logic [31:0] s_rdata; int hold;
        int e_lat; logic [1:0] e_resp; logic [31:0] e_rdata; logic e_tmo; logic [31:0] e_addr;
        int e_alast; int e_wlast;
    } vec_t;

    typedef struct { logic [31:0] rdata; logic [1:0] resp; logic tmo; } exp_t;

    vec_t vq[$];
    exp_t sb[$];
    int n_chk = 0, n_pass = 0, exp_err = 0;

    int cfg_a = 0, cfg_w = 0, cfg_d = 0;
    logic [1:0]  cfg_resp = 2'b00;
    logic [31:0] cfg_rdata = 32'h0;
    int aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;

    initial begin
        axi.axi_awready_i = 0; axi.axi_wready_i = 0; axi.axi_arready_i = 0;
        axi.axi_bvalid_i = 0; axi.axi_rvalid_i = 0;
        axi.axi_bresp_i = 0; axi.axi_rresp_i = 0; axi.axi_rdata_i = 0;
    end

    // Slave model: each ready/valid rises after its configured number of wait cycles.
    always @(negedge sclk) begin
        axi.axi_bresp_i = cfg_resp;
        axi.axi_rresp_i = cfg_resp;
        axi.axi_rdata_i = cfg_rdata;
        if (reset) begin
            axi.axi_awready_i = 0; axi.axi_wready_i = 0; axi.axi_arready_i = 0;
            axi.axi_bvalid_i = 0; axi.axi_rvalid_i = 0;
            aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
        end else begin
            if (axi.axi_awvalid_o) begin axi.axi_awready_i = (aw_wait == cfg_a); aw_wait++; end
            else begin axi.axi_awready_i = 0; aw_wait = 0; end
            if (axi.axi_wvalid_o) begin axi.axi_wready_i = (w_wait == cfg_w); w_wait++; end
            else begin axi.axi_wready_i = 0; w_wait = 0; end
            if (axi.axi_arvalid_o) begin axi.axi_arready_i = (ar_wait == cfg_a); ar_wait++; end
            else begin axi.axi_arready_i = 0; ar_wait = 0; end
            if (axi.axi_bready_o) begin axi.axi_bvalid_i = (b_wait == cfg_d); b_wait++; end
            else begin axi.axi_bvalid_i = 0; b_wait = 0; end
            if (axi.axi_rready_o) begin axi.axi_rvalid_i = (r_wait == cfg_d); r_wait++; end
            else begin axi.axi_rvalid_i = 0; r_wait = 0; end
        end
    end

    function automatic vec_t mk(logic wr, logic [15:0] addr, logic [31:0] wdata, logic [3:0] wstrb,
                                int a, int w, int d, logic [1:0] sresp, logic [31:0] srdata, int hold,
                                int lat, logic [1:0] eresp, logic [31:0] erdata, logic etmo,
                                logic [31:0] eaddr, int alast, int wlast);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb;
        v.a_dly = a; v.w_dly = w; v.d_dly = d; v.s_resp = sresp; v.s_rdata = srdata; v.hold = hold;
        v.e_lat = lat; v.e_resp = eresp; v.e_rdata = erdata; v.e_tmo = etmo; v.e_addr = eaddr;
        v.e_alast = alast; v.e_wlast = wlast;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic drive_cmd(input vec_t v, output bit ok);
        int g;
        cfg_a = v.a_dly; cfg_w = v.w_dly; cfg_d = v.d_dly;
        cfg_resp = v.s_resp; cfg_rdata = v.s_rdata;
        @(negedge sclk);
        cmd_write_i = v.wr; cmd_addr_i = v.addr; cmd_wdata_i = v.wdata; cmd_wstrb_i = v.wstrb;
        cmd_valid_i = 1'b1;
        g = 0;
        while (!cmd_ready_o && g < 20) begin @(negedge sclk); g++; end
        if (!cmd_ready_o) begin
            chk("accept_wait", 32'(cmd_ready_o), 32'h1);
            cmd_valid_i = 1'b0;
            ok = 1'b0;
            return;
        end
        @(posedge sclk);
        #1 cmd_valid_i = 1'b0;
        ok = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        exp_t e, got;
        bit ok;
        int lat, alast, wlast;
        logic [31:0] a_seen, wd_seen;
        logic [3:0]  ws_seen;
        e.rdata = v.e_rdata; e.resp = v.e_resp; e.tmo = v.e_tmo;
        sb.push_back(e);
        if (v.e_resp != 2'b00 && exp_err < 65535) exp_err++;
        drive_cmd(v, ok);
        if (!ok) begin sb.delete(sb.size() - 1); return; end
        lat = 0; alast = 0; wlast = 0; a_seen = '0; wd_seen = '0; ws_seen = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge sclk);
            if (v.wr) begin
                if (axi.axi_awvalid_o) begin alast = k; a_seen = axi.axi_awaddr_o; end
                if (axi.axi_wvalid_o) begin wlast = k; wd_seen = axi.axi_wdata_o; ws_seen = axi.axi_wstrb_o; end
            end else if (axi.axi_arvalid_o) begin
                alast = k; a_seen = axi.axi_araddr_o;
            end
            if (rsp_valid_o) begin lat = k; break; end
        end
        chk({nm, " latency"}, 32'(lat), 32'(v.e_lat));
        chk({nm, " addr"}, a_seen, v.e_addr);
        chk({nm, " addr_valid_last"}, 32'(alast), 32'(v.e_alast));
        if (v.wr) begin
            chk({nm, " wvalid_last"}, 32'(wlast), 32'(v.e_wlast));
            chk({nm, " wdata"}, wd_seen, v.wdata);
            chk({nm, " wstrb"}, 32'(ws_seen), 32'(v.wstrb));
        end
        if (lat == 0) begin sb.delete(0); return; end
        for (int h = 0; h < v.hold; h++) begin
            cmd_valid_i = 1'b1;
            chk({nm, " hold cmd_ready"}, 32'(cmd_ready_o), 32'h0);
            chk({nm, " hold rsp"}, {rsp_rdata_o[28:0], rsp_resp_o, rsp_valid_o},
                {v.e_rdata[28:0], v.e_resp, 1'b1});
            @(negedge sclk);
        end
        cmd_valid_i = 1'b0;
        chk({nm, " rsp_valid"}, 32'(rsp_valid_o), 32'h1);
        got = sb.pop_front();
        chk({nm, " rdata"}, rsp_rdata_o, got.rdata);
        chk({nm, " resp"}, 32'(rsp_resp_o), 32'(got.resp));
        chk({nm, " timeout"}, 32'(rsp_timeout_o), 32'(got.tmo));
        chk({nm, " err_cnt"}, 32'(err_cnt_o), 32'(exp_err));
        rsp_ready_i = 1'b1;
        @(posedge sclk);
        #1 rsp_ready_i = 1'b0;
        @(negedge sclk);
        chk({nm, " ready_after_rsp"}, {31'h0, cmd_ready_o}, 32'h1);
        chk({nm, " rsp_dropped"}, {31'h0, rsp_valid_o}, 32'h0);
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, " cmd_ready"}, 32'(cmd_ready_o), 32'h1);
        chk({nm, " valids"}, {26'h0, rsp_valid_o, axi.axi_awvalid_o, axi.axi_wvalid_o,
            axi.axi_bready_o, axi.axi_arvalid_o, axi.axi_rready_o}, 32'h0);
        chk({nm, " err_cnt"}, 32'(err_cnt_o), 32'h0);
        chk({nm, " rsp"}, rsp_rdata_o | 32'(rsp_resp_o) | 32'(rsp_timeout_o), 32'h0);
        chk({nm, " bus"}, axi.axi_awaddr_o | axi.axi_araddr_o | axi.axi_wdata_o | 32'(axi.axi_wstrb_o), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        bit ok;
        int g;
        vec_t v;
        //     wr addr      wdata          strb a   w   d  sr rdata           hld lat er erdata          tmo addr           al wl
        vq.push_back(mk(1, 16'h0000, 32'h0000_0003, 4'hF, 0,  0,  0, 0, 32'h0,          0, 3, 0, 32'h0,          0, 32'h4000_0000, 1, 1));
        vq.push_back(mk(1, 16'h0804, 32'h1234_5678, 4'h3, 4,  2,  0, 0, 32'h0,          0, 7, 0, 32'h0,          0, 32'h4000_0804, 5, 3));
        vq.push_back(mk(0, 16'h1004, 32'h0,         4'h0, 0,  0,  3, 0, 32'hDEAD_BEEF,  0, 6, 0, 32'hDEAD_BEEF,  0, 32'h4000_1004, 1, 0));
        vq.push_back(mk(0, 16'h0013, 32'h0,         4'h0, 0,  0,  0, 0, 32'hA5A5_0001,  0, 3, 0, 32'hA5A5_0001,  0, 32'h4000_0010, 1, 0));
        vq.push_back(mk(1, 16'h0800, 32'hCAFE_0000, 4'hF, 200,200,0, 0, 32'h0,          0, 9, 3, 32'h0,          1, 32'h4000_0800, 8, 8));
        vq.push_back(mk(1, 16'h0008, 32'h0000_0040, 4'hF, 0,  0,  0, 2, 32'h0,          4, 3, 2, 32'h0,          0, 32'h4000_0008, 1, 1));
        vq.push_back(mk(0, 16'h1000, 32'h0,         4'h0, 200,0,  0, 0, 32'h0000_1111,  0, 9, 3, 32'h0,          1, 32'h4000_1000, 8, 0));
        vq.push_back(mk(0, 16'h000C, 32'h0,         4'h0, 0,  0,  0, 3, 32'h0000_0055,  0, 3, 3, 32'h0000_0055,  0, 32'h4000_000C, 1, 0));
        vq.push_back(mk(0, 16'h0004, 32'h0,         4'h0, 7,  0,  0, 0, 32'h0000_00AA,  0, 10,0, 32'h0000_00AA,  0, 32'h4000_0004, 8, 0));
        vq.push_back(mk(1, 16'h0FFC, 32'hFFFF_0001, 4'h1, 7,  7,  0, 0, 32'h0,          0, 10,0, 32'h0,          0, 32'h4000_0FFC, 8, 8));
        vq.push_back(mk(1, 16'h0100, 32'h0000_0005, 4'h8, 0,  7,  0, 0, 32'h0,          0, 10,0, 32'h0,          0, 32'h4000_0100, 1, 8));
        vq.push_back(mk(1, 16'h0010, 32'h0000_0009, 4'hF, 0,  0,  200,0,32'h0,          0, 9, 3, 32'h0,          1, 32'h4000_0010, 1, 1));
        vq.push_back(mk(1, 16'h0014, 32'h0000_0007, 4'hF, 0,  0,  6, 0, 32'h0,          0, 9, 0, 32'h0,          0, 32'h4000_0014, 1, 1));
        vq.push_back(mk(0, 16'h17FC, 32'h0,         4'h0, 0,  0,  6, 0, 32'h7777_0000,  0, 9, 0, 32'h7777_0000,  0, 32'h4000_17FC, 1, 0));

        repeat (3) @(negedge sclk);
        check_reset_outputs("reset");
        reset = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            run_vec(vq[i], $sformatf("vec%0d", i));
        end

        // Asynchronous reset while waiting on B must abandon the command at once.
        v = vq[0];
        v.d_dly = 200;
        drive_cmd(v, ok);
        g = 0;
        while (!axi.axi_bready_o && g < 20) begin @(negedge sclk); g++; end
        chk("rst_mid reached_wr_b", 32'(axi.axi_bready_o), 32'h1);
        #2 reset = 1'b1;
        #1 check_reset_outputs("rst_mid");
        exp_err = 0;
        @(negedge sclk);
        reset = 1'b0;
        run_vec(vq[0], "after_reset");
        run_vec(vq[2], "after_reset_rd");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axil_reg_master.md
# axil_reg_master

AXI-Lite initiator driving the `bram2udp` register/BRAM window (base 0x4000_0000) from a simple command/response port. Each command is one 32-bit register read or write: INT_ENABLE, SDLEN, STATUS, TX BRAM 0x0800–0x0FFF, RX BRAM 0x1000–0x17FF, etc. It serves the packet/command path that configures the slave, fills the TX BRAM and drains the RX BRAM. One transaction is in flight at a time, with a timeout and an error counter.

## Interface
- `BASEADDR`, 32'h4000_0000: OR-ed with the 16-bit command offset to form the AXI address.
- `TIMEOUT_CYCLES`, 16'd1024: cycles allowed from command accept to B/R handshake; 0 disables the timeout.

Clock and reset are one clock; reset is asynchronous and active-high.

- `sclk` in 1: clock.
- `reset` in 1: asynchronous active-high reset.
- `cmd_valid_i` in 1: command request.
- `cmd_ready_o` out 1: command accepted when `cmd_valid_i & cmd_ready_o`.
- `cmd_write_i` in 1: 1 = write, 0 = read.
- `cmd_addr_i` in 16: byte offset; bits [1:0] ignored, forced to 0 on the bus.
- `cmd_wdata_i` in 32: write data.
- `cmd_wstrb_i` in 4: write strobes.
- `rsp_valid_o` out 1: response available.
- `rsp_ready_i` in 1: response consumed.
- `rsp_rdata_o` out 32: read data; 0 for writes.
- `rsp_resp_o` out 2: captured BRESP/RRESP; 2'b11 on timeout.
- `rsp_timeout_o` out 1: response produced by timeout.
- `err_cnt_o` out 16: saturating count of non-OKAY responses plus timeouts.
- `axi_awaddr_o` out 32, `axi_awvalid_o` out 1, `axi_awready_i` in 1: write address channel.
- `axi_wdata_o` out 32, `axi_wstrb_o` out 4, `axi_wvalid_o` out 1, `axi_wready_i` in 1: write data channel.
- `axi_bresp_i` in 2, `axi_bvalid_i` in 1, `axi_bready_o` out 1: write response channel.
- `axi_araddr_o` out 32, `axi_arvalid_o` out 1, `axi_arready_i` in 1: read address channel.
- `axi_rdata_i` in 32, `axi_rresp_i` in 2, `axi_rvalid_i` in 1, `axi_rready_o` out 1: read data channel.

## Operation
- **Reset values.** All outputs are 0 except `cmd_ready_o`, which is 1. The state machine resets to IDLE.
- **IDLE.**
  - `cmd_ready_o` = 1.
  - On accept, latch address, data, strobe and direction, and clear the timeout counter.
  - Go to WR (write) or RD_A (read). `cmd_ready_o` drops in the same edge.
- **WR.**
  - `axi_awvalid_o` and `axi_wvalid_o` both assert from the first WR cycle.
  - Each is held until its own handshake, then dropped on the next edge; they are independent.
  - AW first, W first or simultaneous completion are all legal.
  - When both channels are done, go to WR_B.
- **WR_B.**
  - `axi_bready_o` = 1.
  - On `axi_bvalid_i`, capture `axi_bresp_i`, set `rsp_rdata_o` = 0, and go to RSP.
- **RD_A.** `axi_arvalid_o` is held until `axi_arready_i`, then go to RD_R.
- **RD_R.**
  - `axi_rready_o` = 1.
  - On `axi_rvalid_i`, capture `axi_rdata_i` and `axi_rresp_i`, and go to RSP.
- **RSP.**
  - `rsp_valid_o` = 1 with stable data.
  - On `rsp_ready_i`, return to IDLE.
  - No new command is accepted while in RSP.
- **Timeout.**
  - The counter increments in WR, WR_B, RD_A and RD_R.
  - When it reaches `TIMEOUT_CYCLES`, all AXI valid/ready outputs deassert on the next edge.
  - The response is then `rsp_resp_o` = 2'b11, `rsp_timeout_o` = 1, `rsp_rdata_o` = 0, and the state goes to RSP.
  - Deasserting VALID this way is a deliberate recovery path. It fires only on a hung slave.
- **Simultaneous events.** A handshake in the same cycle the counter hits the limit counts as success; the timeout is not taken.
- **Error counter.** `err_cnt_o` increments once per response with `rsp_resp_o` != 0 and saturates at 0xFFFF. It is cleared only by reset.
- **Reset mid-transaction.** All AXI valids and `rsp_valid_o` drop asynchronously, and the command is lost.

## Timing
- All outputs are registered; there is no combinational input→output path.
- Zero-wait slave, write:
  - Cycle 0: accept.
  - Cycle 1: AW and W valid, both handshake.
  - Cycle 2: `axi_bready_o` = 1, slave asserts `axi_bvalid_i`.
  - Cycle 3: `rsp_valid_o` = 1.
- Zero-wait slave, read:
  - Cycle 0: accept.
  - Cycle 1: AR handshake.
  - Cycle 2: R handshake.
  - Cycle 3: `rsp_valid_o` = 1.
- Back-to-back throughput: the next command can be accepted the cycle after the `rsp_valid_o & rsp_ready_i` handshake.
- Timeout response appears `TIMEOUT_CYCLES`+1 cycles after accept.

## Structure
- Shared package `bram2udp_pkg` holds:
  - register offsets INT_ENABLE 0x0000, INT_STATUS 0x0004, SDLEN 0x0008, RDLEN 0x000C, STATUS 0x0010;
  - window bounds TX 0x0800–0x0FFF and RX 0x1000–0x17FF;
  - AXI response codes OKAY 0, SLVERR 2, DECERR 3, and timeout code 3;
  - the state encoding.
- Single flat module; no sub-module.

## Test plan
- Zero-wait slave, write 0x0000_0003 to offset 0x0000 → AW address 0x4000_0000, WSTRB 0xF, `rsp_valid_o` in cycle 3, `rsp_resp_o` = 0.
- Slave gives `axi_wready_i` 2 cycles before `axi_awready_i` (delay 5) → `axi_wvalid_o` drops after the W handshake, AW stays high until cycle 5, single B accepted, `rsp_resp_o` = 0.
- Read offset 0x1004, slave returns 0xDEAD_BEEF after 3 wait cycles → `axi_araddr_o` = 0x4000_1004, `rsp_rdata_o` = 0xDEAD_BEEF.
- Silent slave, `TIMEOUT_CYCLES` = 8 → valids drop, response in cycle 9 with `rsp_resp_o` = 3, `rsp_timeout_o` = 1, `err_cnt_o` = 1.
- SLVERR on BRESP, and `rsp_ready_i` held low for 4 cycles → response stable for 4 cycles, `cmd_ready_o` = 0 throughout, `err_cnt_o` +1.
- Assert `reset` while in WR_B → all outputs return to reset values immediately; next command completes normally.
